// File: rtl/orderbook_levels_if.sv
// Update request/response and published top-of-book depth bundle for orderbook_levels.
// The feed side drives master; the book drives slave.
interface orderbook_levels_if #(
   parameter int PRICE_WIDTH = 32,
   parameter int QTY_WIDTH   = 32,
   parameter int TOP_N       = 4
) ();
   logic                         upd_valid;
   logic                         upd_ready;
   logic                         upd_side;
   logic [1:0]                   upd_op;
   logic [PRICE_WIDTH-1:0]       upd_price;
   logic [QTY_WIDTH-1:0]         upd_qty;
   logic                         book_clear;
   logic                         upd_done;
   logic [1:0]                   upd_status;
   logic [TOP_N*PRICE_WIDTH-1:0] bid_px;
   logic [TOP_N*QTY_WIDTH-1:0]   bid_qty;
   logic [TOP_N-1:0]             bid_vld;
   logic [TOP_N*PRICE_WIDTH-1:0] ask_px;
   logic [TOP_N*QTY_WIDTH-1:0]   ask_qty;
   logic [TOP_N-1:0]             ask_vld;
   logic [15:0]                  bid_count;
   logic [15:0]                  ask_count;
   logic                         crossed;

   modport master (
      output upd_valid, upd_side, upd_op, upd_price, upd_qty, book_clear,
      input  upd_ready, upd_done, upd_status,
      input  bid_px, bid_qty, bid_vld, ask_px, ask_qty, ask_vld,
      input  bid_count, ask_count, crossed
   );

   modport slave (
      input  upd_valid, upd_side, upd_op, upd_price, upd_qty, book_clear,
      output upd_ready, upd_done, upd_status,
      output bid_px, bid_qty, bid_vld, ask_px, ask_qty, ask_vld,
      output bid_count, ask_count, crossed
   );
endinterface

// File: rtl/orderbook_levels.sv
// Price-level order book: sorted per-side level arrays updated by side/price/delta messages,
// publishing top-N depth, level counts and a crossed flag. One update in flight at a time.
module orderbook_levels #(
   parameter int PRICE_WIDTH = 32,
   parameter int QTY_WIDTH   = 32,
   parameter int LEVELS      = 16,
   parameter int TOP_N       = 4
) (
   input  logic              clk,
   input  logic              rst,
   orderbook_levels_if.slave ob
);
   localparam int IW = $clog2(LEVELS + 1);

   localparam logic [1:0] OP_ADD       = 2'd0;
   localparam logic [1:0] OP_REDUCE    = 2'd1;
   localparam logic [1:0] OP_DELETE    = 2'd2;
   localparam logic [1:0] ST_OK        = 2'd0;
   localparam logic [1:0] ST_NOT_FOUND = 2'd1;
   localparam logic [1:0] ST_FULL_DROP = 2'd2;
   localparam logic [1:0] ST_EVICTED   = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_APPLY, S_RESP} state_t;

   state_t                 state, state_nxt;
   logic                   accept;

   logic [PRICE_WIDTH-1:0] lvl_px  [2][LEVELS];
   logic [QTY_WIDTH-1:0]   lvl_qty [2][LEVELS];
   logic [IW-1:0]          lvl_cnt [2];
   logic [TOP_N-1:0]       bid_vld_q, ask_vld_q;
   logic                   crossed_q;
   logic [1:0]             status_q;

   logic                   req_side_p0;
   logic [1:0]             req_op_p0;
   logic [PRICE_WIDTH-1:0] req_price_p0;
   logic [QTY_WIDTH-1:0]   req_qty_p0;

   logic                   s_hit;
   logic [IW-1:0]          s_hit_idx, s_ins_idx, s_cnt;
   logic [QTY_WIDTH-1:0]   s_hit_qty;
   logic                   hit_p1;
   logic [IW-1:0]          hit_idx_p1, ins_idx_p1;
   logic [QTY_WIDTH-1:0]   hit_qty_p1;

   logic [PRICE_WIDTH-1:0] a_px  [LEVELS];
   logic [QTY_WIDTH-1:0]   a_qty [LEVELS];
   logic [IW-1:0]          a_cnt;
   logic [1:0]             a_status;
   logic                   do_sat, do_sub, do_ins, do_rem;
   logic [IW-1:0]          p_bid_cnt, p_ask_cnt;
   logic [PRICE_WIDTH-1:0] p_bid_best, p_ask_best;

   logic [TOP_N*PRICE_WIDTH-1:0] bid_px_w, ask_px_w;
   logic [TOP_N*QTY_WIDTH-1:0]   bid_qty_w, ask_qty_w;

   function automatic logic [QTY_WIDTH-1:0] sat_add(input logic [QTY_WIDTH-1:0] a,
                                                    input logic [QTY_WIDTH-1:0] b);
      logic [QTY_WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[QTY_WIDTH] ? {QTY_WIDTH{1'b1}} : sum[QTY_WIDTH-1:0];
   endfunction

   // Bids rank higher prices first, asks rank lower prices first.
   function automatic logic is_better(input logic side,
                                      input logic [PRICE_WIDTH-1:0] a,
                                      input logic [PRICE_WIDTH-1:0] b);
      return side ? (a < b) : (a > b);
   endfunction

   function automatic logic [TOP_N-1:0] vld_mask(input logic [IW-1:0] cnt);
      logic [TOP_N-1:0] m;
      m = '0;
      for (int i = 0; i < TOP_N; i++) m[i] = (IW'(i) < cnt);
      return m;
   endfunction

   assign accept = (state == S_IDLE) && ob.upd_valid && !ob.book_clear;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (ob.book_clear) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (ob.upd_valid) state_nxt = S_SEARCH;
            S_SEARCH: state_nxt = S_APPLY;
            S_APPLY:  state_nxt = S_RESP;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      ob.upd_ready = (state == S_IDLE);
      ob.upd_done  = (state == S_RESP);
   end

   // Stage p0: request captured on the accept edge.
   always_ff @(posedge clk) begin
      if (accept) begin
         req_side_p0  <= ob.upd_side;
         req_op_p0    <= ob.upd_op;
         req_price_p0 <= ob.upd_price;
         req_qty_p0   <= ob.upd_qty;
      end
   end

   // Insert index is the first valid slot the request beats, else the first free slot;
   // scanning from the worst end lets the lowest qualifying index win.
   always_comb begin
      s_cnt     = lvl_cnt[req_side_p0];
      s_hit     = 1'b0;
      s_hit_idx = '0;
      s_hit_qty = '0;
      s_ins_idx = s_cnt;
      for (int i = LEVELS - 1; i >= 0; i--) begin
         if (IW'(i) < s_cnt) begin
            if (lvl_px[req_side_p0][i] == req_price_p0) begin
               s_hit     = 1'b1;
               s_hit_idx = IW'(i);
               s_hit_qty = lvl_qty[req_side_p0][i];
            end
            if (!is_better(req_side_p0, lvl_px[req_side_p0][i], req_price_p0))
               s_ins_idx = IW'(i);
         end
      end
   end

   // Stage p1: search result registered at the end of SEARCH.
   always_ff @(posedge clk) begin
      if (state == S_SEARCH) begin
         hit_p1     <= s_hit;
         hit_idx_p1 <= s_hit_idx;
         ins_idx_p1 <= s_ins_idx;
         hit_qty_p1 <= s_hit_qty;
      end
   end

   always_comb begin
      a_cnt    = lvl_cnt[req_side_p0];
      a_status = ST_OK;
      do_sat   = 1'b0;
      do_sub   = 1'b0;
      do_ins   = 1'b0;
      do_rem   = 1'b0;
      case (req_op_p0)
         OP_ADD: begin
            if (hit_p1) begin
               do_sat = 1'b1;
            end else if (req_qty_p0 != '0) begin
               if (ins_idx_p1 < IW'(LEVELS)) begin
                  do_ins = 1'b1;
                  if (a_cnt == IW'(LEVELS)) a_status = ST_EVICTED;
               end else begin
                  a_status = ST_FULL_DROP;
               end
            end
         end
         OP_REDUCE: begin
            if (!hit_p1)                      a_status = ST_NOT_FOUND;
            else if (req_qty_p0 < hit_qty_p1) do_sub   = 1'b1;
            else                              do_rem   = 1'b1;
         end
         OP_DELETE: begin
            if (!hit_p1) a_status = ST_NOT_FOUND;
            else         do_rem   = 1'b1;
         end
         default: a_status = ST_NOT_FOUND;
      endcase

      for (int i = 0; i < LEVELS; i++) begin
         a_px[i]  = lvl_px[req_side_p0][i];
         a_qty[i] = lvl_qty[req_side_p0][i];
         if (IW'(i) == hit_idx_p1) begin
            if (do_sat) a_qty[i] = sat_add(hit_qty_p1, req_qty_p0);
            if (do_sub) a_qty[i] = hit_qty_p1 - req_qty_p0;
         end
      end

      // Insert shifts worse levels down; on a full side the worst falls off the end.
      if (do_ins) begin
         for (int i = 1; i < LEVELS; i++) begin
            if (IW'(i) > ins_idx_p1) begin
               a_px[i]  = lvl_px[req_side_p0][i-1];
               a_qty[i] = lvl_qty[req_side_p0][i-1];
            end
         end
         for (int i = 0; i < LEVELS; i++) begin
            if (IW'(i) == ins_idx_p1) begin
               a_px[i]  = req_price_p0;
               a_qty[i] = req_qty_p0;
            end
         end
         if (a_cnt != IW'(LEVELS)) a_cnt = a_cnt + IW'(1);
      end

      if (do_rem) begin
         for (int i = 0; i < LEVELS - 1; i++) begin
            if (IW'(i) >= hit_idx_p1) begin
               a_px[i]  = lvl_px[req_side_p0][i+1];
               a_qty[i] = lvl_qty[req_side_p0][i+1];
            end
         end
         a_px[LEVELS-1]  = '0;
         a_qty[LEVELS-1] = '0;
         a_cnt           = a_cnt - IW'(1);
      end

      p_bid_cnt  = req_side_p0 ? lvl_cnt[0]   : a_cnt;
      p_ask_cnt  = req_side_p0 ? a_cnt        : lvl_cnt[1];
      p_bid_best = req_side_p0 ? lvl_px[0][0] : a_px[0];
      p_ask_best = req_side_p0 ? a_px[0]      : lvl_px[1][0];
   end

   // Stage p2: book, masks, crossed flag and status commit together at the end of APPLY.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < LEVELS; i++) begin
               lvl_px[s][i]  <= '0;
               lvl_qty[s][i] <= '0;
            end
            lvl_cnt[s] <= '0;
         end
         bid_vld_q <= '0;
         ask_vld_q <= '0;
         crossed_q <= 1'b0;
         status_q  <= ST_OK;
      end else if (ob.book_clear) begin
         for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < LEVELS; i++) begin
               lvl_px[s][i]  <= '0;
               lvl_qty[s][i] <= '0;
            end
            lvl_cnt[s] <= '0;
         end
         bid_vld_q <= '0;
         ask_vld_q <= '0;
         crossed_q <= 1'b0;
      end else if (state == S_APPLY) begin
         for (int i = 0; i < LEVELS; i++) begin
            lvl_px[req_side_p0][i]  <= a_px[i];
            lvl_qty[req_side_p0][i] <= a_qty[i];
         end
         lvl_cnt[req_side_p0] <= a_cnt;
         bid_vld_q <= vld_mask(p_bid_cnt);
         ask_vld_q <= vld_mask(p_ask_cnt);
         crossed_q <= (p_bid_cnt != '0) && (p_ask_cnt != '0) && (p_bid_best >= p_ask_best);
         status_q  <= a_status;
      end
   end

   // Invalid slots always hold zero, so depth is a straight view of the leading entries.
   always_comb begin
      bid_px_w  = '0;
      bid_qty_w = '0;
      ask_px_w  = '0;
      ask_qty_w = '0;
      for (int i = 0; i < TOP_N; i++) begin
         bid_px_w[i*PRICE_WIDTH +: PRICE_WIDTH] = lvl_px[0][i];
         bid_qty_w[i*QTY_WIDTH +: QTY_WIDTH]    = lvl_qty[0][i];
         ask_px_w[i*PRICE_WIDTH +: PRICE_WIDTH] = lvl_px[1][i];
         ask_qty_w[i*QTY_WIDTH +: QTY_WIDTH]    = lvl_qty[1][i];
      end
   end

   assign ob.bid_px     = bid_px_w;
   assign ob.bid_qty    = bid_qty_w;
   assign ob.bid_vld    = bid_vld_q;
   assign ob.ask_px     = ask_px_w;
   assign ob.ask_qty    = ask_qty_w;
   assign ob.ask_vld    = ask_vld_q;
   assign ob.bid_count  = 16'(lvl_cnt[0]);
   assign ob.ask_count  = 16'(lvl_cnt[1]);
   assign ob.crossed    = crossed_q;
   assign ob.upd_status = status_q;
endmodule

// File: tb/tb_orderbook_levels.sv
// Directed bench for orderbook_levels (LEVELS=4) with a queue-based reference book and
// a scoreboard of expected post-update snapshots.
module tb_orderbook_levels;
   localparam int PW = 32;
   localparam int QW = 32;
   localparam int LV = 4;
   localparam int TN = 4;

   localparam logic [1:0] ADD = 2'd0, RED = 2'd1, DEL = 2'd2, RSV = 2'd3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   orderbook_levels_if #(.PRICE_WIDTH(PW), .QTY_WIDTH(QW), .TOP_N(TN)) ob ();

   orderbook_levels #(.PRICE_WIDTH(PW), .QTY_WIDTH(QW), .LEVELS(LV), .TOP_N(TN)) dut (
      .clk (clk),
      .rst (rst),
      .ob  (ob)
   );

   typedef struct packed {
      logic [PW-1:0] px;
      logic [QW-1:0] qty;
   } lvl_t;

   typedef struct packed {
      logic [1:0]       st;
      logic [TN*PW-1:0] bpx;
      logic [TN*QW-1:0] bqty;
      logic [TN-1:0]    bv;
      logic [TN*PW-1:0] apx;
      logic [TN*QW-1:0] aqty;
      logic [TN-1:0]    av;
      logic [15:0]      bc;
      logic [15:0]      ac;
      logic             cr;
   } exp_t;

   lvl_t m_bid[$];
   lvl_t m_ask[$];
   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   step     = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL step%0d %s observed=%0h expected=%0h", step, tag, obs, exp);
      end
   endtask

   task automatic model_apply(input logic side, input logic [1:0] op, input logic [PW-1:0] px,
                              input logic [QW-1:0] qty, output logic [1:0] st);
      lvl_t q[$];
      lvl_t nl;
      int idx;
      int pos;
      logic [QW:0] sum;
      if (side) q = m_ask;
      else      q = m_bid;
      idx = -1;
      for (int i = 0; i < q.size(); i++) if (q[i].px == px) idx = i;
      st = 2'd0;
      case (op)
         ADD: begin
            if (idx >= 0) begin
               sum = {1'b0, q[idx].qty} + {1'b0, qty};
               q[idx].qty = sum[QW] ? {QW{1'b1}} : sum[QW-1:0];
            end else if (qty != 0) begin
               pos = q.size();
               for (int i = 0; i < q.size(); i++) begin
                  if (side ? (px < q[i].px) : (px > q[i].px)) begin
                     pos = i;
                     break;
                  end
               end
               nl.px  = px;
               nl.qty = qty;
               q.insert(pos, nl);
               if (q.size() > LV) begin
                  if (pos == LV) begin
                     q.delete(pos);
                     st = 2'd2;
                  end else begin
                     void'(q.pop_back());
                     st = 2'd3;
                  end
               end
            end
         end
         RED: begin
            if (idx < 0)                st = 2'd1;
            else if (qty < q[idx].qty)  q[idx].qty = q[idx].qty - qty;
            else                        q.delete(idx);
         end
         DEL: begin
            if (idx < 0) st = 2'd1;
            else         q.delete(idx);
         end
         default: st = 2'd1;
      endcase
      if (side) m_ask = q;
      else      m_bid = q;
   endtask

   function automatic exp_t model_snap(input logic [1:0] st);
      exp_t e;
      e = '0;
      e.st = st;
      for (int i = 0; i < TN; i++) begin
         if (i < m_bid.size()) begin
            e.bpx[i*PW +: PW]  = m_bid[i].px;
            e.bqty[i*QW +: QW] = m_bid[i].qty;
            e.bv[i]            = 1'b1;
         end
         if (i < m_ask.size()) begin
            e.apx[i*PW +: PW]  = m_ask[i].px;
            e.aqty[i*QW +: QW] = m_ask[i].qty;
            e.av[i]            = 1'b1;
         end
      end
      e.bc = 16'(m_bid.size());
      e.ac = 16'(m_ask.size());
      if (m_bid.size() > 0 && m_ask.size() > 0) e.cr = (m_bid[0].px >= m_ask[0].px);
      return e;
   endfunction

   task automatic compare_book(input exp_t e);
      chk("bid_px",    ob.bid_px,    e.bpx);
      chk("bid_qty",   ob.bid_qty,   e.bqty);
      chk("bid_vld",   ob.bid_vld,   e.bv);
      chk("ask_px",    ob.ask_px,    e.apx);
      chk("ask_qty",   ob.ask_qty,   e.aqty);
      chk("ask_vld",   ob.ask_vld,   e.av);
      chk("bid_count", ob.bid_count, e.bc);
      chk("ask_count", ob.ask_count, e.ac);
      chk("crossed",   ob.crossed,   e.cr);
   endtask

   task automatic send(input logic side, input logic [1:0] op, input logic [PW-1:0] px,
                       input logic [QW-1:0] qty);
      logic [1:0] st;
      exp_t e;
      int lat;
      logic got;
      step++;
      @(negedge clk);
      chk("ready_idle", ob.upd_ready, 1);
      ob.upd_valid = 1'b1;
      ob.upd_side  = side;
      ob.upd_op    = op;
      ob.upd_price = px;
      ob.upd_qty   = qty;
      @(posedge clk);
      model_apply(side, op, px, qty, st);
      sb.push_back(model_snap(st));
      @(negedge clk);
      ob.upd_valid = 1'b0;
      lat = 1;
      got = ob.upd_done;
      while (!got && lat < 12) begin
         @(negedge clk);
         lat++;
         got = ob.upd_done;
      end
      chk("done_latency", got ? lat : 999, 3);
      e = sb.pop_front();
      if (got) begin
         chk("status", ob.upd_status, e.st);
         compare_book(e);
      end
      @(negedge clk);
      chk("done_single_pulse", ob.upd_done, 0);
   endtask

   // Starts an update and kills it with rst (in APPLY) or book_clear (in SEARCH).
   task automatic abort_mid(input logic use_rst);
      int ndone;
      step++;
      @(negedge clk);
      ob.upd_valid = 1'b1;
      ob.upd_side  = 1'b0;
      ob.upd_op    = ADD;
      ob.upd_price = 32'd7777;
      ob.upd_qty   = 32'd5;
      @(posedge clk);
      @(negedge clk);
      ob.upd_valid = 1'b0;
      if (use_rst) begin
         @(negedge clk);
         rst = 1'b1;
         #1;
         chk("rst_async_ready", ob.upd_ready, 1);
         chk("rst_async_count", ob.bid_count, 0);
      end else begin
         ob.book_clear = 1'b1;
      end
      m_bid.delete();
      m_ask.delete();
      @(negedge clk);
      ndone = int'(ob.upd_done);
      rst = 1'b0;
      ob.book_clear = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ndone += int'(ob.upd_done);
      end
      chk("abort_no_done", ndone, 0);
      chk("abort_ready", ob.upd_ready, 1);
      compare_book(model_snap(2'd0));
   endtask

   task automatic clear_with_valid();
      int ndone;
      step++;
      @(negedge clk);
      ob.upd_valid  = 1'b1;
      ob.book_clear = 1'b1;
      ob.upd_side   = 1'b1;
      ob.upd_op     = ADD;
      ob.upd_price  = 32'd12345;
      ob.upd_qty    = 32'd9;
      @(negedge clk);
      chk("clear_ready_high", ob.upd_ready, 1);
      ob.book_clear = 1'b0;
      ob.upd_valid  = 1'b0;
      m_bid.delete();
      m_ask.delete();
      ndone = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ndone += int'(ob.upd_done);
      end
      chk("clear_no_done", ndone, 0);
      compare_book(model_snap(2'd0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at step %0d", step);
      $fatal(1, "timeout");
   end

   initial begin
      rst           = 1'b1;
      ob.upd_valid  = 1'b0;
      ob.upd_side   = 1'b0;
      ob.upd_op     = ADD;
      ob.upd_price  = '0;
      ob.upd_qty    = '0;
      ob.book_clear = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready",  ob.upd_ready, 1);
      chk("rst_done",   ob.upd_done, 0);
      chk("rst_status", ob.upd_status, 0);
      compare_book(model_snap(2'd0));
      rst = 1'b0;

      send(1'b0, ADD, 32'd10000, 32'd100);
      send(1'b0, ADD, 32'd10050, 32'd75);
      send(1'b1, ADD, 32'd10100, 32'd50);
      send(1'b0, ADD, 32'd10000, 32'd200);
      send(1'b0, RED, 32'd10000, 32'd300);
      send(1'b0, RED, 32'd9999,  32'd1);

      send(1'b0, ADD, 32'd9000, 32'hFFFF_FFF0);
      send(1'b0, ADD, 32'd9000, 32'h20);
      send(1'b0, RED, 32'd9000, 32'd1);
      send(1'b0, RSV, 32'd9000, 32'd5);
      send(1'b0, DEL, 32'd9000, 32'd0);

      send(1'b0, ADD, 32'd10200, 32'd10);
      send(1'b0, DEL, 32'd10200, 32'd0);
      send(1'b1, DEL, 32'd10300, 32'd0);

      clear_with_valid();

      send(1'b1, ADD, 32'd102, 32'd5);
      send(1'b1, ADD, 32'd100, 32'd6);
      send(1'b1, ADD, 32'd103, 32'd7);
      send(1'b1, ADD, 32'd101, 32'd8);
      send(1'b1, ADD, 32'd104, 32'd9);
      send(1'b1, ADD, 32'd99,  32'd10);
      send(1'b1, ADD, 32'd98,  32'd0);
      send(1'b1, RED, 32'd101, 32'd8);

      send(1'b0, ADD, 32'd10, 32'd1);
      send(1'b0, ADD, 32'd30, 32'd3);
      send(1'b0, ADD, 32'd20, 32'd2);
      send(1'b0, ADD, 32'd40, 32'd4);
      send(1'b0, ADD, 32'd5,  32'd5);
      send(1'b0, ADD, 32'd45, 32'd6);
      send(1'b0, ADD, 32'd99, 32'd7);

      abort_mid(1'b1);
      send(1'b1, ADD, 32'd500, 32'd1);
      send(1'b0, ADD, 32'd600, 32'd2);
      abort_mid(1'b0);
      send(1'b0, ADD, 32'd300, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
